// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button event front end.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } btn_state_e;

    localparam int unsigned STABLE_W = 32'd4;

    // Bits needed to hold values 0..value-1 (never less than one bit).
    function automatic int unsigned clog2w(input int unsigned value);
        int unsigned result;
        result = 32'd1;
        for (int unsigned i = 32'd1; i < 32'd32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 32'd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, tick-sampled debounce,
// hold-time FSM and single-cycle event pulses.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = 32'd3,
    parameter int unsigned LONG_TICKS     = 32'd200,
    parameter int unsigned REPEAT_TICKS   = 32'd40,
    parameter bit          ACTIVE_LOW     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int unsigned HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int unsigned HOLD_W   = clog2w(HOLD_MAX + 32'd1);

    localparam logic [HOLD_W-1:0]   HOLD_ZERO   = HOLD_W'(0);
    localparam logic [HOLD_W-1:0]   HOLD_ONE    = HOLD_W'(1);
    localparam logic [HOLD_W-1:0]   LONG_C      = HOLD_W'(LONG_TICKS);
    localparam logic [HOLD_W-1:0]   REPEAT_C    = HOLD_W'(REPEAT_TICKS);
    localparam logic [STABLE_W-1:0] STABLE_ZERO = STABLE_W'(0);
    localparam logic [STABLE_W-1:0] STABLE_ONE  = STABLE_W'(1);
    localparam logic [STABLE_W-1:0] STABLE_C    = STABLE_W'(STABLE_SAMPLES);

    logic                raw_pol_s;
    logic                sync1_r;
    logic                sync2_r;
    logic [STABLE_W-1:0] stable_cnt_r;
    logic [STABLE_W-1:0] stable_cnt_nx_s;
    logic                level_r;
    logic                level_nx_s;
    logic                rise_s;
    logic                fall_s;
    btn_state_e          state_r;
    btn_state_e          state_nx_s;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [HOLD_W-1:0]   hold_cnt_nx_s;
    logic [HOLD_W-1:0]   hold_inc_s;
    logic                long_nx_s;
    logic                repeat_nx_s;
    logic                press_r;
    logic                release_r;
    logic                long_r;
    logic                repeat_r;

    // Polarity is corrected ahead of the synchroniser so its reset value is "released".
    assign raw_pol_s  = btn_raw ^ ACTIVE_LOW;
    assign hold_inc_s = hold_cnt_r + HOLD_ONE;

    // Two-flop synchroniser, clocked every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw_pol_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: count consecutive differing samples, flip level on the last one.
    always_comb begin
        stable_cnt_nx_s = stable_cnt_r;
        level_nx_s      = level_r;
        rise_s          = 1'b0;
        fall_s          = 1'b0;
        if (tick) begin
            if (sync2_r != level_r) begin
                if ((stable_cnt_r + STABLE_ONE) == STABLE_C) begin
                    level_nx_s      = ~level_r;
                    stable_cnt_nx_s = STABLE_ZERO;
                    rise_s          = ~level_r;
                    fall_s          = level_r;
                end else begin
                    stable_cnt_nx_s = stable_cnt_r + STABLE_ONE;
                end
            end else begin
                stable_cnt_nx_s = STABLE_ZERO;
            end
        end else begin
            stable_cnt_nx_s = stable_cnt_r;
        end
    end

    // Hold-time FSM; a falling level always wins over long/repeat.
    always_comb begin
        state_nx_s    = state_r;
        hold_cnt_nx_s = hold_cnt_r;
        long_nx_s     = 1'b0;
        repeat_nx_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nx_s    = HELD;
                    hold_cnt_nx_s = HOLD_ZERO;
                end else begin
                    state_nx_s    = IDLE;
                end
            end
            HELD: begin
                if (fall_s) begin
                    state_nx_s    = IDLE;
                    hold_cnt_nx_s = HOLD_ZERO;
                end else if (tick) begin
                    if (hold_inc_s == LONG_C) begin
                        long_nx_s     = 1'b1;
                        hold_cnt_nx_s = HOLD_ZERO;
                        state_nx_s    = LONG;
                    end else begin
                        hold_cnt_nx_s = hold_inc_s;
                    end
                end else begin
                    hold_cnt_nx_s = hold_cnt_r;
                end
            end
            LONG: begin
                if (fall_s) begin
                    state_nx_s    = IDLE;
                    hold_cnt_nx_s = HOLD_ZERO;
                end else if (tick) begin
                    if (hold_inc_s == REPEAT_C) begin
                        repeat_nx_s   = 1'b1;
                        hold_cnt_nx_s = HOLD_ZERO;
                    end else begin
                        hold_cnt_nx_s = hold_inc_s;
                    end
                end else begin
                    hold_cnt_nx_s = hold_cnt_r;
                end
            end
            default: begin
                state_nx_s    = IDLE;
                hold_cnt_nx_s = HOLD_ZERO;
            end
        endcase
    end

    // State, counters and registered event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt_r <= STABLE_ZERO;
            level_r      <= 1'b0;
            state_r      <= IDLE;
            hold_cnt_r   <= HOLD_ZERO;
            press_r      <= 1'b0;
            release_r    <= 1'b0;
            long_r       <= 1'b0;
            repeat_r     <= 1'b0;
        end else begin
            stable_cnt_r <= stable_cnt_nx_s;
            level_r      <= level_nx_s;
            state_r      <= state_nx_s;
            hold_cnt_r   <= hold_cnt_nx_s;
            press_r      <= rise_s;
            release_r    <= fall_s;
            long_r       <= long_nx_s;
            repeat_r     <= repeat_nx_s;
        end
    end

    assign level_o   = level_r;
    assign press_o   = press_r;
    assign release_o = release_r;
    assign long_o    = long_r;
    assign repeat_o  = repeat_r;

endmodule

// File: rtl/button_event_detector.sv
// Multi-channel push-button front end: shared sample-tick generator feeding
// N_BTN independent debounce/event channels.
module button_event_detector
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN          = 32'd4,
    parameter int unsigned TICK_DIV       = 32'd250000,
    parameter int unsigned STABLE_SAMPLES = 32'd3,
    parameter int unsigned LONG_TICKS     = 32'd200,
    parameter int unsigned REPEAT_TICKS   = 32'd40,
    parameter bit          ACTIVE_LOW     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic             tick_o,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] long_o,
    output logic [N_BTN-1:0] repeat_o
);

    localparam int unsigned       TICK_W    = clog2w(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 32'd1);

    logic [TICK_W-1:0] tick_cnt_r;
    logic [TICK_W-1:0] tick_cnt_nx_s;
    logic              tick_r;

    // Tick counter wraps at TICK_DIV-1.
    always_comb begin
        tick_cnt_nx_s = tick_cnt_r;
        if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_nx_s = TICK_ZERO;
        end else begin
            tick_cnt_nx_s = tick_cnt_r + TICK_ONE;
        end
    end

    // tick_r is pre-decoded so it is high exactly while the counter sits at TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= TICK_ZERO;
            tick_r     <= 1'b0;
        end else begin
            tick_cnt_r <= tick_cnt_nx_s;
            tick_r     <= (tick_cnt_nx_s == TICK_LAST);
        end
    end

    assign tick_o = tick_r;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_channel #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .LONG_TICKS     (LONG_TICKS),
            .REPEAT_TICKS   (REPEAT_TICKS),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick_r),
            .btn_raw   (btn_raw[g]),
            .level_o   (level_o[g]),
            .press_o   (press_o[g]),
            .release_o (release_o[g]),
            .long_o    (long_o[g]),
            .repeat_o  (repeat_o[g])
        );
    end

endmodule

// File: tb/tb_button_event_detector.sv
// Directed bench for button_event_detector with a short tick (TICK_DIV=4)
// plus a second, active-low instance.
module tb_button_event_detector;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic       tick_o;
    logic [3:0] level_o, press_o, release_o, long_o, repeat_o;
    logic [3:0] btn_raw_al;
    logic       tick_al;
    logic [3:0] level_al, press_al, release_al, long_al, repeat_al;

    int n_vec = 0;
    int n_err = 0;

    button_event_detector #(
        .N_BTN(4), .TICK_DIV(4), .STABLE_SAMPLES(3),
        .LONG_TICKS(5), .REPEAT_TICKS(2), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .tick_o(tick_o),
        .level_o(level_o), .press_o(press_o), .release_o(release_o),
        .long_o(long_o), .repeat_o(repeat_o)
    );

    button_event_detector #(
        .N_BTN(4), .TICK_DIV(4), .STABLE_SAMPLES(3),
        .LONG_TICKS(5), .REPEAT_TICKS(2), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw_al), .tick_o(tick_al),
        .level_o(level_al), .press_o(press_al), .release_o(release_al),
        .long_o(long_al), .repeat_o(repeat_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next tick-evaluation edge (bounded wait).
    task automatic step_tick;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (tick_o) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL tick_timeout: tick_o=0 for 8 clk, required a tick");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        int press_seen, press_cyc;
        rst_n = 1'b0; btn_raw = 4'hF; btn_raw_al = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({tick_o, level_o, press_o, release_o, long_o, repeat_o,
             tick_al, level_al, press_al, release_al, long_al, repeat_al} !== 42'd0) begin
            n_err++;
            $display("FAIL reset_hold: outputs=%h al=%h required 0",
                     {tick_o, level_o, press_o, release_o, long_o, repeat_o},
                     {tick_al, level_al, press_al, release_al, long_al, repeat_al});
        end
        @(negedge clk); rst_n = 1'b1;
        press_seen = 0; press_cyc = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (tick_o !== (((i % 4) == 3) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL tick_pattern: cycle %0d tick_o=%b required %b", i, tick_o, ((i % 4) == 3));
            end
            if (i <= 2) begin
                n_vec++;
                if ({level_o, press_o, release_o, long_o, repeat_o} !== 20'd0) begin
                    n_err++;
                    $display("FAIL post_reset_quiet: cycle %0d outputs=%h required 0", i,
                             {level_o, press_o, release_o, long_o, repeat_o});
                end
            end
            if (press_o !== 4'h0) begin
                press_seen++; press_cyc = i;
                n_vec++;
                if (press_o !== 4'hF) begin
                    n_err++;
                    $display("FAIL reset_press_value: press_o=%h required F", press_o);
                end
            end
        end
        n_vec++;
        if (press_seen != 1) begin
            n_err++;
            $display("FAIL reset_press_count: got %0d pulses required 1", press_seen);
        end
        n_vec++;
        if (press_cyc < 9 || press_cyc > 13) begin
            n_err++;
            $display("FAIL reset_press_latency: cycle %0d required 9..13", press_cyc);
        end
        n_vec++;
        if (level_o !== 4'hF) begin
            n_err++;
            $display("FAIL reset_level: level_o=%h required F", level_o);
        end
        n_vec++;
        if (level_al !== 4'h0) begin
            n_err++;
            $display("FAIL al_idle_level: level_al=%h required 0", level_al);
        end
    endtask

    task automatic test_release_all;
        btn_raw = 4'h0;
        for (int k = 1; k <= 3; k++) begin
            step_tick();
            n_vec++;
            if (release_o !== ((k == 3) ? 4'hF : 4'h0) || long_o !== 4'h0) begin
                n_err++;
                $display("FAIL release_all: tick %0d release_o=%h long_o=%h required %h/0",
                         k, release_o, long_o, (k == 3) ? 4'hF : 4'h0);
            end
        end
        n_vec++;
        if (level_o !== 4'h0) begin
            n_err++;
            $display("FAIL release_all_level: level_o=%h required 0", level_o);
        end
    endtask

    task automatic test_glitch;
        btn_raw = 4'b0010;
        for (int k = 1; k <= 5; k++) begin
            step_tick();
            if (k == 2) btn_raw = 4'b0000;
            n_vec++;
            if (press_o !== 4'h0 || level_o !== 4'h0) begin
                n_err++;
                $display("FAIL glitch: tick %0d press_o=%h level_o=%h required 0/0", k, press_o, level_o);
            end
        end
        btn_raw = 4'b0010;
        for (int k = 1; k <= 3; k++) begin
            step_tick();
            n_vec++;
            if (press_o !== ((k == 3) ? 4'b0010 : 4'b0000)) begin
                n_err++;
                $display("FAIL glitch_press: tick %0d press_o=%h required %h",
                         k, press_o, (k == 3) ? 4'b0010 : 4'b0000);
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if (press_o !== 4'h0 || level_o !== 4'b0010) begin
            n_err++;
            $display("FAIL press_width: press_o=%h level_o=%h required 0/2", press_o, level_o);
        end
        btn_raw = 4'b0000;
        for (int k = 1; k <= 3; k++) begin
            step_tick();
            n_vec++;
            if (release_o !== ((k == 3) ? 4'b0010 : 4'b0000)) begin
                n_err++;
                $display("FAIL glitch_release: tick %0d release_o=%h", k, release_o);
            end
        end
    endtask

    task automatic test_long_repeat;
        btn_raw = 4'b0001;
        repeat (3) step_tick();
        n_vec++;
        if (press_o !== 4'b0001) begin
            n_err++;
            $display("FAIL lr_press: press_o=%h required 1", press_o);
        end
        for (int k = 1; k <= 15; k++) begin
            step_tick();
            n_vec++;
            if (long_o[0] !== (k == 5) || repeat_o[0] !== (k == 7 || k == 9 || k == 11) ||
                release_o[0] !== (k == 13) || level_o[0] !== (k < 13)) begin
                n_err++;
                $display("FAIL long_repeat: T+%0d long=%b rep=%b rel=%b lvl=%b required %b%b%b%b", k,
                         long_o[0], repeat_o[0], release_o[0], level_o[0],
                         (k == 5), (k == 7 || k == 9 || k == 11), (k == 13), (k < 13));
            end
            if (k == 10) btn_raw = 4'b0000;
        end
    endtask

    task automatic test_collision;
        btn_raw = 4'b0100;
        repeat (3) step_tick();
        n_vec++;
        if (press_o !== 4'b0100) begin
            n_err++;
            $display("FAIL col_press: press_o=%h required 4", press_o);
        end
        for (int k = 1; k <= 8; k++) begin
            step_tick();
            n_vec++;
            if (long_o[2] !== 1'b0 || repeat_o[2] !== 1'b0 || release_o[2] !== (k == 5)) begin
                n_err++;
                $display("FAIL collision: P+%0d long=%b rep=%b rel=%b required 0 0 %b",
                         k, long_o[2], repeat_o[2], release_o[2], (k == 5));
            end
            if (k == 2) btn_raw = 4'b0000;
        end
    endtask

    task automatic test_async_reset;
        int press_seen;
        logic [3:0] press_val;
        btn_raw = 4'b1000;
        repeat (3) step_tick();
        for (int k = 1; k <= 7; k++) begin
            step_tick();
            n_vec++;
            if (long_o[3] !== (k == 5) || repeat_o[3] !== (k == 7)) begin
                n_err++;
                $display("FAIL ar_long_repeat: P+%0d long=%b rep=%b required %b %b",
                         k, long_o[3], repeat_o[3], (k == 5), (k == 7));
            end
        end
        rst_n = 1'b0;
        #2;
        n_vec++;
        if ({tick_o, level_o, press_o, release_o, long_o, repeat_o} !== 21'd0) begin
            n_err++;
            $display("FAIL async_reset: outputs=%h required 0 without clk edge",
                     {tick_o, level_o, press_o, release_o, long_o, repeat_o});
        end
        @(negedge clk); rst_n = 1'b1;
        press_seen = 0; press_val = 4'h0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (press_o !== 4'h0) begin
                press_seen++; press_val = press_o;
            end
        end
        n_vec++;
        if (press_seen != 1 || press_val !== 4'b1000) begin
            n_err++;
            $display("FAIL ar_repress: %0d pulses value=%h required 1 pulse of 8", press_seen, press_val);
        end
        for (int k = 2; k <= 5; k++) begin
            step_tick();
            n_vec++;
            if (long_o[3] !== (k == 5)) begin
                n_err++;
                $display("FAIL ar_long: press+%0d long=%b required %b", k, long_o[3], (k == 5));
            end
        end
    endtask

    task automatic test_active_low;
        int press_seen;
        logic [3:0] press_val;
        btn_raw_al = 4'hE;
        press_seen = 0; press_val = 4'h0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (press_al !== 4'h0) begin
                press_seen++; press_val = press_al;
            end
        end
        n_vec++;
        if (press_seen != 1 || press_val !== 4'h1) begin
            n_err++;
            $display("FAIL active_low_press: %0d pulses value=%h required 1 pulse of 1", press_seen, press_val);
        end
        n_vec++;
        if (level_al !== 4'h1) begin
            n_err++;
            $display("FAIL active_low_level: level_al=%h required 1", level_al);
        end
    endtask

    initial begin
        test_reset();
        test_release_all();
        test_glitch();
        test_long_repeat();
        test_collision();
        test_async_reset();
        test_active_low();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
